// File: rtl/mmio_gpio_bank.sv
// Memory-mapped WIDTH-bit output bank with set/clear/toggle aliases and a
// free-running blink engine that XORs a mask into the outputs every blink_div+1 cycles.
module mmio_gpio_bank #(
    parameter logic [31:0]       BASE_ADDR = 32'h1000_0000,
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic [WIDTH-1:0] gpio_out
);

    typedef enum logic [2:0] {
        OFF_OUT   = 3'd0,
        OFF_SET   = 3'd1,
        OFF_CLR   = 3'd2,
        OFF_TOG   = 3'd3,
        OFF_MASK  = 3'd4,
        OFF_DIV   = 3'd5,
        OFF_INFO  = 3'd6,
        OFF_RSVD  = 3'd7
    } reg_off_e;

    reg_off_e         offset;
    logic             hit;
    logic             accept;
    logic             write_en;
    logic             div_write;
    logic             tick;
    logic [31:0]      byte_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] blink_mask;
    logic [WIDTH-1:0] blinked;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] mask_next;
    logic [31:0]      blink_div;
    logic [31:0]      blink_cnt;
    logic [31:0]      div_next;
    logic [31:0]      read_val;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
    assign accept    = valid && hit && !ready;
    assign offset    = reg_off_e'(addr[4:2]);
    assign write_en  = accept && (wstrb != 4'b0000);
    assign div_write = write_en && (offset == OFF_DIV);

    always_comb begin
        byte_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{wstrb[i]}};
        end
    end

    assign wmask = byte_mask[WIDTH-1:0];
    assign wbits = wdata[WIDTH-1:0] & wmask;

    // A BLINK_DIV write restarts the period, so it suppresses the tick in its own cycle.
    assign tick    = (blink_div != '0) && (blink_cnt == blink_div) && !div_write;
    assign blinked = tick ? (out_reg ^ blink_mask) : out_reg;

    // CPU writes are layered on top of the blink result so unwritten bits still blink.
    always_comb begin
        out_next  = blinked;
        mask_next = blink_mask;
        div_next  = blink_div;
        if (write_en) begin
            case (offset)
                OFF_OUT:  out_next  = (blinked & ~wmask) | wbits;
                OFF_SET:  out_next  = blinked | wbits;
                OFF_CLR:  out_next  = blinked & ~wbits;
                OFF_TOG:  out_next  = blinked ^ wbits;
                OFF_MASK: mask_next = (blink_mask & ~wmask) | wbits;
                OFF_DIV:  div_next  = (blink_div & ~byte_mask) | (wdata & byte_mask);
                default:  ;
            endcase
        end
    end

    always_comb begin
        read_val = '0;
        case (offset)
            OFF_OUT:  read_val[WIDTH-1:0] = out_reg;
            OFF_MASK: read_val[WIDTH-1:0] = blink_mask;
            OFF_DIV:  read_val            = blink_div;
            OFF_INFO: read_val[5:0]       = 6'(WIDTH);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg    <= RESET_VAL;
            blink_mask <= '0;
            blink_div  <= '0;
            blink_cnt  <= '0;
            ready      <= 1'b0;
            rdata      <= '0;
        end else begin
            out_reg    <= out_next;
            blink_mask <= mask_next;
            blink_div  <= div_next;
            if (div_write || (blink_div == '0) || tick) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
            ready <= accept;
            rdata <= accept ? read_val : '0;
        end
    end

    assign gpio_out = out_reg;

endmodule

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
Parametrised memory-mapped output bank and the successor to the single LED register. It provides a WIDTH-bit output register with atomic set, clear and toggle aliases, plus a hardware blink engine that periodically toggles masked bits with no CPU involvement. It sits on the CPU's simple valid/ready peripheral bus alongside SRAM and other MMIO slaves. It drives board LEDs or GPIO pins directly.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; must be 32-byte aligned; the window spans BASE_ADDR..BASE_ADDR+0x1F
WIDTH, 8, number of output bits, 1..32
RESET_VAL, 0, reset value of the output register, WIDTH bits

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
valid  input  1  CPU access request
addr  input  32  byte address
wdata  input  32  write data
wstrb  input  4  byte write strobes; non-zero means write, zero means read
rdata  output  32  read data, registered
ready  output  1  one-cycle completion pulse, registered
gpio_out  output  WIDTH  current output register value, driven directly from the flop

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low, sampled on posedge clk when rst_n=0. Reset values: out_reg=RESET_VAL, blink_mask=0, blink_div=0, blink_cnt=0, ready=0, rdata=0.
- Window hit: addr[31:5]==BASE_ADDR[31:5]. Register offset is addr[4:2]. addr[1:0] is ignored.
- Accept: a request is accepted when valid && hit && !ready. Each accept produces exactly one ready pulse on the next cycle. If valid is held high, an accept happens every other cycle, and each write takes effect once per pulse.
- Non-accept cycles: ready=0 and rdata=0. Requests outside the window get no response at all.
- Read data: rdata is the register value before any write in the same transaction, whether or not wstrb is non-zero.
- Register map:
  - 0x00 OUT: RW, byte-strobed.
  - 0x04 SET: write-1-to-set, reads 0.
  - 0x08 CLR: write-1-to-clear, reads 0.
  - 0x0C TOG: write-1-to-toggle, reads 0.
  - 0x10 BLINK_MASK: RW, WIDTH bits.
  - 0x14 BLINK_DIV: RW, 32 bits.
  - 0x18 INFO: RO; returns WIDTH in [5:0], zero elsewhere. Writes are ignored.
  - 0x1C: reserved; reads 0, writes are ignored, ready is still returned.
- Byte strobes: wdata bits take effect only within bytes whose wstrb bit is set. This applies to every writable register, including SET/CLR/TOG.
- Width: bits at or above WIDTH read 0 and ignore writes.
- Blink divider:
  - If blink_div==0, blink is disabled and blink_cnt is held at 0.
  - Otherwise blink_cnt increments every cycle. When blink_cnt==blink_div, tick=1 and blink_cnt returns to 0. The tick period is therefore blink_div+1 cycles.
  - An accepted write to BLINK_DIV clears blink_cnt to 0 in that same cycle. No tick occurs in that cycle.
- Tick action: on a tick, out_reg ^= blink_mask.
- Simultaneous CPU write and tick, resolved per bit:
  - OUT write: strobed bits take wdata; all other bits take the blink result.
  - SET/CLR write: bits written with 1 are forced to 1/0; all other bits take the blink result.
  - TOG write: new = old ^ cpu_toggle ^ (tick ? blink_mask : 0). Both toggles apply.
  - BLINK_MASK write coincident with a tick: the tick uses the old mask.
- gpio_out reflects out_reg updates the cycle after the write or tick edge. It equals out_reg at all times.
- Reset mid-transaction: ready drops to 0 on the reset edge and no pending write commits. After reset the CPU must reissue the request.

Test Plan:
- Reset with RESET_VAL=8'hA5 → gpio_out=8'hA5, ready=0, rdata=0. Read OUT → single ready pulse, rdata=32'h0000_00A5.
- WIDTH=8: write OUT 32'hFFFF_FF3C with wstrb=4'b0001 → gpio_out=8'h3C, and a read returns 32'h0000_003C. Write 32'h0000_0055 with wstrb=4'b0010 → gpio_out unchanged.
- From OUT=8'h0F: SET 8'hF0 → 8'hFF; CLR 8'h81 → 8'h7E; TOG 8'hFF → 8'h81. Reads of SET/CLR/TOG return 0.
- BLINK_MASK=8'h01, BLINK_DIV=3, OUT=0 → bit0 toggles every 4 cycles, counted from the BLINK_DIV write. Write BLINK_DIV=0 → toggling stops and the current value is held.
- A tick coincides with a TOG write of 8'h01 and BLINK_MASK=8'h03 → bit0 is unchanged, bit1 toggles. A coincident OUT write of 8'h00 (wstrb=4'b0001) → OUT=8'h00.
- valid held high for 6 cycles on a SET write → ready=1,0,1,0,1,0 with 3 accepts. Address BASE_ADDR+0x20 → no ready. INFO read → 32'h0000_0008. Pulse rst_n low during a pending write → no commit, ready=0.
